// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch unit: owns the fetch PC, streams sequential word requests and buffers responses
// with their PCs in a DEPTH-entry queue. Optional misaligned-redirect trap: FETCH_MISALIGN_TRAP_EN.
module fetch_prefetch_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     DEPTH        = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            fetch_misaligned
`endif
);

  localparam int unsigned     PW      = $clog2(DEPTH);
  localparam int unsigned     CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     q_data [DEPTH];
  logic [XLEN-1:0] q_pc   [DEPTH];

  logic [XLEN-1:0] target;
  logic            blocked;
  logic            req_fire;
  logic            rsp_fire;
  logic            push;
  logic            pop;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned_q, misaligned_d;

  assign target           = redirect_target;
  assign blocked          = misaligned_q;
  assign fetch_misaligned = misaligned_q;

  always_comb begin
    misaligned_d = misaligned_q;
    if (redirect_valid) misaligned_d = |redirect_target[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) misaligned_q <= 1'b0;
    else       misaligned_q <= misaligned_d;
  end
`else
  assign target  = redirect_target & {{(XLEN-2){1'b1}}, 2'b00};
  assign blocked = 1'b0;
`endif

  // Queue space is reserved when a request is issued, so responses can never overflow it.
  assign imem_req_valid = !reset && !redirect_valid && !blocked &&
                          (({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_W);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_fire       = imem_rsp_valid && !reset;
  assign push           = rsp_fire && (drop_q == '0) && !redirect_valid;

  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid && inst_ready;
  assign inst_data  = inst_valid ? q_data[rd_ptr_q] : '0;
  assign inst_pc    = inst_valid ? q_pc[rd_ptr_q]   : '0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    drop_d     = drop_q;
    outst_d    = outst_q + CW'(req_fire) - CW'(rsp_fire);
    count_d    = count_q + CW'(push) - CW'(pop);

    if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
    if (rsp_fire && (drop_q != '0)) drop_d = drop_q - CW'(1);
    if (push) begin
      resp_pc_d = resp_pc_q + PC_STEP;
      wr_ptr_d  = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    // Every request still in flight after this cycle's response becomes a discard.
    if (redirect_valid) begin
      fetch_pc_d = target;
      resp_pc_d  = target;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      drop_d     = outst_q - CW'(rsp_fire);
      outst_d    = outst_q - CW'(rsp_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_VECTOR;
      resp_pc_q  <= RESET_VECTOR;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr_q] <= imem_rsp_data;
      q_pc[wr_ptr_q]   <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a fixed-latency in-order memory model.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
  logic        s_mis;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int lat = 1;
  logic junk_rsp = 1'b0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  logic        s_req_valid, s_req_fire, s_inst_valid, s_inst_fire;
  logic [31:0] s_req_addr, s_inst_pc, s_inst_data;

  fetch_prefetch_unit #(.XLEN(32), .RESET_VECTOR(32'h100), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .fetch_misaligned(fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // One cycle: drive memory response, sample outputs mid-cycle, advance to the next negedge.
  task automatic tick();
    logic drove;
    drove = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_addr[0]);
      drove = 1'b1;
    end else if (junk_rsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hFFFF_FFFF;
    end
    #1;
    s_req_valid  = imem_req_valid;
    s_req_addr   = imem_req_addr;
    s_req_fire   = imem_req_valid && imem_req_ready;
    s_inst_valid = inst_valid;
    s_inst_fire  = inst_valid && inst_ready;
    s_inst_pc    = inst_pc;
    s_inst_data  = inst_data;
`ifdef FETCH_MISALIGN_TRAP_EN
    s_mis = fetch_misaligned;
`endif
    if (drove) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (s_req_fire) begin
      pend_addr.push_back(s_req_addr);
      pend_due.push_back(cyc + lat);
    end
    if (reset) begin
      pend_addr.delete();
      pend_due.delete();
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = '0;
    imem_req_ready = 1'b0;
    inst_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    junk_rsp = 1'b1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = '0;
    tick();
    tick();
    vectors++;
    if ({s_req_valid, s_req_addr} !== {1'b0, 32'h100}) begin
      miscompares++;
      $display("FAIL reset_req: got valid=%b addr=%h expected valid=0 addr=00000100", s_req_valid, s_req_addr);
    end
    vectors++;
    if ({s_inst_valid, s_inst_data, s_inst_pc} !== 65'd0) begin
      miscompares++;
      $display("FAIL reset_inst: got v=%b d=%h pc=%h expected all zero", s_inst_valid, s_inst_data, s_inst_pc);
    end
    reset = 1'b0;
    junk_rsp = 1'b0;
    imem_req_ready = 1'b0;
    inst_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if ({s_req_valid, s_req_addr} !== {1'b1, 32'h100}) begin
        miscompares++;
        $display("FAIL post_reset_req[%0d]: got valid=%b addr=%h expected valid=1 addr=00000100", i, s_req_valid, s_req_addr);
      end
      vectors++;
      if (s_inst_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_inst[%0d]: got valid=%b expected 0", i, s_inst_valid);
      end
    end
  endtask

  task automatic test_sequential();
    logic [31:0] pc;
    do_reset();
    lat = 1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if ({s_req_fire, s_req_addr} !== {1'b1, 32'h100 + 32'(4 * i)}) begin
        miscompares++;
        $display("FAIL seq_req[%0d]: got fire=%b addr=%h expected fire=1 addr=%h", i, s_req_fire, s_req_addr, 32'h100 + 32'(4 * i));
      end
      pc = (i < 2) ? 32'h0 : 32'h100 + 32'(4 * (i - 2));
      vectors++;
      if ({s_inst_valid, s_inst_pc, s_inst_data} !== {(i >= 2), pc, (i < 2) ? 32'h0 : mem_word(pc)}) begin
        miscompares++;
        $display("FAIL seq_inst[%0d]: got v=%b pc=%h d=%h expected v=%b pc=%h", i, s_inst_valid, s_inst_pc, s_inst_data, (i >= 2), pc);
      end
    end
  endtask

  task automatic test_stall();
    int nreq;
    logic [31:0] pc;
    do_reset();
    lat = 1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b0;
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_req_fire) nreq++;
    end
    vectors++;
    if (nreq !== 4) begin
      miscompares++;
      $display("FAIL stall_req_count: got %0d expected 4", nreq);
    end
    vectors++;
    if ({s_req_valid, s_inst_valid, s_inst_pc} !== {1'b0, 1'b1, 32'h100}) begin
      miscompares++;
      $display("FAIL stall_hold: got req_v=%b inst_v=%b pc=%h expected req_v=0 inst_v=1 pc=00000100", s_req_valid, s_inst_valid, s_inst_pc);
    end
    inst_ready = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      tick();
      if (j == 1) begin
        vectors++;
        if (s_req_fire !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_first_pop_req: got fire=%b expected 0", s_req_fire);
        end
      end
      if (j == 2) begin
        vectors++;
        if ({s_req_fire, s_req_addr} !== {1'b1, 32'h110}) begin
          miscompares++;
          $display("FAIL stall_resume_req: got fire=%b addr=%h expected fire=1 addr=00000110", s_req_fire, s_req_addr);
        end
      end
      pc = 32'h100 + 32'(4 * (j - 1));
      vectors++;
      if ({s_inst_fire, s_inst_pc, s_inst_data} !== {1'b1, pc, mem_word(pc)}) begin
        miscompares++;
        $display("FAIL stall_drain[%0d]: got fire=%b pc=%h d=%h expected pc=%h", j, s_inst_fire, s_inst_pc, s_inst_data, pc);
      end
    end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    lat = 3;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    redirect_target = 32'h200;
    for (int c = 0; c < 10; c++) begin
      redirect_valid = (c == 3);
      tick();
      redirect_valid = 1'b0;
      if (c >= 3 && c <= 7) begin
        vectors++;
        if (s_inst_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL inflight_no_stale[%0d]: got valid=%b pc=%h expected valid=0", c, s_inst_valid, s_inst_pc);
        end
      end
      if (c == 3) begin
        vectors++;
        if (s_req_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL inflight_redirect_req: got valid=%b expected 0", s_req_valid);
        end
      end
      if (c == 4) begin
        vectors++;
        if ({s_req_fire, s_req_addr} !== {1'b1, 32'h200}) begin
          miscompares++;
          $display("FAIL inflight_target_req: got fire=%b addr=%h expected fire=1 addr=00000200", s_req_fire, s_req_addr);
        end
      end
      if (c == 8 || c == 9) begin
        vectors++;
        if ({s_inst_valid, s_inst_pc, s_inst_data} !== {1'b1, 32'h200 + 32'(4 * (c - 8)), mem_word(32'h200 + 32'(4 * (c - 8)))}) begin
          miscompares++;
          $display("FAIL inflight_target_inst[%0d]: got v=%b pc=%h d=%h expected pc=%h", c, s_inst_valid, s_inst_pc, s_inst_data, 32'h200 + 32'(4 * (c - 8)));
        end
      end
    end
  endtask

  task automatic test_redirect_coincident();
    do_reset();
    lat = 2;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    redirect_target = 32'h300;
    for (int c = 0; c < 9; c++) begin
      redirect_valid = (c == 3);
      tick();
      redirect_valid = 1'b0;
      if (c == 3) begin
        vectors++;
        if ({s_inst_fire, s_inst_pc, s_inst_data} !== {1'b1, 32'h100, mem_word(32'h100)}) begin
          miscompares++;
          $display("FAIL coinc_head_consumed: got fire=%b pc=%h d=%h expected fire=1 pc=00000100", s_inst_fire, s_inst_pc, s_inst_data);
        end
      end
      if (c == 4) begin
        vectors++;
        if ({s_req_fire, s_req_addr} !== {1'b1, 32'h300}) begin
          miscompares++;
          $display("FAIL coinc_target_req: got fire=%b addr=%h expected fire=1 addr=00000300", s_req_fire, s_req_addr);
        end
      end
      if (c >= 4 && c <= 6) begin
        vectors++;
        if (s_inst_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL coinc_empty[%0d]: got valid=%b pc=%h d=%h expected valid=0", c, s_inst_valid, s_inst_pc, s_inst_data);
        end
      end
      if (c == 7 || c == 8) begin
        vectors++;
        if ({s_inst_valid, s_inst_pc, s_inst_data} !== {1'b1, 32'h300 + 32'(4 * (c - 7)), mem_word(32'h300 + 32'(4 * (c - 7)))}) begin
          miscompares++;
          $display("FAIL coinc_target_inst[%0d]: got v=%b pc=%h d=%h expected pc=%h", c, s_inst_valid, s_inst_pc, s_inst_data, 32'h300 + 32'(4 * (c - 7)));
        end
      end
    end
  endtask

  task automatic test_req_ready_toggle();
    logic [31:0] exp_addr, exp_pc;
    int nreq, ninst;
    do_reset();
    lat = 1;
    inst_ready = 1'b1;
    exp_addr = 32'h100;
    exp_pc = 32'h100;
    nreq = 0;
    ninst = 0;
    for (int c = 0; c < 20; c++) begin
      imem_req_ready = (c % 2 == 0);
      tick();
      if (s_req_fire) begin
        vectors++;
        if (s_req_addr !== exp_addr) begin
          miscompares++;
          $display("FAIL toggle_addr[%0d]: got %h expected %h", c, s_req_addr, exp_addr);
        end
        exp_addr += 32'd4;
        nreq++;
      end
      if (s_inst_fire) begin
        vectors++;
        if ({s_inst_pc, s_inst_data} !== {exp_pc, mem_word(exp_pc)}) begin
          miscompares++;
          $display("FAIL toggle_inst[%0d]: got pc=%h d=%h expected pc=%h d=%h", c, s_inst_pc, s_inst_data, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 32'd4;
        ninst++;
      end
    end
    vectors++;
    if ({nreq, ninst} !== {32'd10, 32'd9}) begin
      miscompares++;
      $display("FAIL toggle_counts: got req=%0d inst=%0d expected req=10 inst=9", nreq, ninst);
    end
  endtask

`ifndef FETCH_MISALIGN_TRAP_EN
  task automatic test_align_wrap();
    do_reset();
    lat = 1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    tick();
    tick();
    tick();
    redirect_target = 32'hFFFF_FFFE;
    for (int c = 0; c < 5; c++) begin
      redirect_valid = (c == 0);
      tick();
      redirect_valid = 1'b0;
      if (c == 1 || c == 2) begin
        vectors++;
        if ({s_req_fire, s_req_addr, s_inst_valid} !== {1'b1, 32'hFFFF_FFFC + 32'(4 * (c - 1)), 1'b0}) begin
          miscompares++;
          $display("FAIL wrap_req[%0d]: got fire=%b addr=%h inst_v=%b expected addr=%h inst_v=0", c, s_req_fire, s_req_addr, s_inst_valid, 32'hFFFF_FFFC + 32'(4 * (c - 1)));
        end
      end
      if (c == 3 || c == 4) begin
        vectors++;
        if ({s_inst_valid, s_inst_pc, s_inst_data} !== {1'b1, 32'hFFFF_FFFC + 32'(4 * (c - 3)), mem_word(32'hFFFF_FFFC + 32'(4 * (c - 3)))}) begin
          miscompares++;
          $display("FAIL wrap_inst[%0d]: got v=%b pc=%h d=%h expected pc=%h", c, s_inst_valid, s_inst_pc, s_inst_data, 32'hFFFF_FFFC + 32'(4 * (c - 3)));
        end
      end
    end
  endtask
`else
  task automatic test_misalign();
    do_reset();
    lat = 1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    tick();
    tick();
    tick();
    for (int c = 0; c < 9; c++) begin
      redirect_valid = (c == 0 || c == 5);
      redirect_target = (c == 0) ? 32'h202 : 32'h300;
      tick();
      redirect_valid = 1'b0;
      if (c == 0) begin
        vectors++;
        if (s_mis !== 1'b0) begin
          miscompares++;
          $display("FAIL mis_before: got %b expected 0", s_mis);
        end
      end
      if (c >= 1 && c <= 5) begin
        vectors++;
        if ({s_mis, s_req_valid, s_inst_valid} !== 3'b100) begin
          miscompares++;
          $display("FAIL mis_blocked[%0d]: got mis=%b req_v=%b inst_v=%b expected mis=1 req_v=0 inst_v=0", c, s_mis, s_req_valid, s_inst_valid);
        end
      end
      if (c == 6) begin
        vectors++;
        if ({s_mis, s_req_fire, s_req_addr} !== {1'b0, 1'b1, 32'h300}) begin
          miscompares++;
          $display("FAIL mis_cleared: got mis=%b fire=%b addr=%h expected mis=0 fire=1 addr=00000300", s_mis, s_req_fire, s_req_addr);
        end
      end
      if (c == 8) begin
        vectors++;
        if ({s_inst_valid, s_inst_pc, s_inst_data} !== {1'b1, 32'h300, mem_word(32'h300)}) begin
          miscompares++;
          $display("FAIL mis_resume_inst: got v=%b pc=%h d=%h expected pc=00000300", s_inst_valid, s_inst_pc, s_inst_data);
        end
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    inst_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_inflight();
    test_redirect_coincident();
    test_req_ready_toggle();
`ifndef FETCH_MISALIGN_TRAP_EN
    test_align_wrap();
`else
    test_misalign();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
